// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_tracker.sv
`default_nettype none
// ============================================================================
// Module      : mc_tracker
// Description : Occupancy FSM, latency counter and destination latch for the
//               multi-cycle execution unit.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_tracker
    import hazard_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int MC_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mc_op_e,
    input  logic [ADDR_W-1:0] rd_e,
    output logic              issue,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [ADDR_W-1:0] mc_rd
);

    localparam logic [3:0] c_CNT_LOAD = 4'(MC_LAT - 2);

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_mc_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_mc_rd <= '0;
        end else if (issue) begin
            r_cnt   <= c_CNT_LOAD;
            r_mc_rd <= rd_e;
        end else if (r_state == BUSY && r_cnt != '0) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // A new op is accepted only when the unit is free or retiring; requests
    // arriving while BUSY are dropped.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (mc_op_e) w_state_next = BUSY;
            BUSY:    if (r_cnt == '0) w_state_next = DONE;
            DONE:    w_state_next = mc_op_e ? BUSY : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        issue   = mc_op_e && (r_state == IDLE || r_state == DONE);
        mc_busy = (r_state != IDLE);
        mc_done = (r_state == DONE);
        mc_rd   = r_mc_rd;
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Pipeline hazard unit: forwarding, load-use and scoreboard
//               stalls for a multi-cycle unit, plus a stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_d,
    input  logic [ADDR_W-1:0] rs2_d,
    input  logic [ADDR_W-1:0] rd_d,
    input  logic              mc_op_d,
    input  logic [ADDR_W-1:0] rs1_e,
    input  logic [ADDR_W-1:0] rs2_e,
    input  logic [ADDR_W-1:0] rd_e,
    input  logic              result_src_e0,
    input  logic              pc_src_e,
    input  logic              mc_op_e,
    input  logic [ADDR_W-1:0] rd_m,
    input  logic [ADDR_W-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [ADDR_W-1:0] mc_rd,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic                r_sb_unused;
    logic [NUM_REGS-1:0] r_sb;
    logic [NUM_REGS-1:0] w_sb_next;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                w_issue;
    logic                w_lw_stall;
    logic                w_sb_stall;
    logic                w_struct_stall;
    logic                w_stall;

    mc_tracker #(
        .ADDR_W (ADDR_W),
        .MC_LAT (MC_LAT)
    ) u_mc_tracker (
        .clk     (clk),
        .rst_n   (rst_n),
        .mc_op_e (mc_op_e),
        .rd_e    (rd_e),
        .issue   (w_issue),
        .mc_busy (mc_busy),
        .mc_done (mc_done),
        .mc_rd   (mc_rd)
    );

    function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] rs);
        if (rs != '0 && rs == rd_m && reg_write_m)      return FWD_M;
        else if (rs != '0 && rs == rd_w && reg_write_w) return FWD_W;
        else                                            return FWD_RF;
    endfunction

    assign forward_ae = fwd_sel(rs1_e);
    assign forward_be = fwd_sel(rs2_e);

    // Set is applied after clear so a retiring register re-issued in the same
    // cycle stays pending.
    always_comb begin
        w_sb_next = r_sb;
        if (mc_done) w_sb_next[mc_rd] = 1'b0;
        if (w_issue && rd_e != '0) w_sb_next[rd_e] = 1'b1;
        w_sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_next;
        end
    end

    assign r_sb_unused = r_sb[0];

    always_comb begin
        w_lw_stall     = result_src_e0 && (rd_e != '0) && (rs1_d == rd_e || rs2_d == rd_e);
        w_sb_stall     = r_sb[rs1_d] | r_sb[rs2_d] | r_sb[rd_d];
        w_struct_stall = mc_op_d && mc_busy;
        w_stall        = w_lw_stall | w_sb_stall | w_struct_stall;
        stall_f        = w_stall;
        stall_d        = w_stall;
        flush_e        = w_stall | pc_src_e;
        flush_d        = pc_src_e;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench for hazard_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int ADDR_W = 5;
    localparam int MC_LAT = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic              mc_op_d, result_src_e0, pc_src_e, mc_op_e;
    logic              reg_write_m, reg_write_w;
    logic              stall_f, stall_d, flush_d, flush_e, mc_busy, mc_done;
    logic [1:0]        forward_ae, forward_be;
    logic [ADDR_W-1:0] mc_rd;
    logic [CNT_W-1:0]  stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .ADDR_W (ADDR_W),
        .MC_LAT (MC_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs1_d         (rs1_d),
        .rs2_d         (rs2_d),
        .rd_d          (rd_d),
        .mc_op_d       (mc_op_d),
        .rs1_e         (rs1_e),
        .rs2_e         (rs2_e),
        .rd_e          (rd_e),
        .result_src_e0 (result_src_e0),
        .pc_src_e      (pc_src_e),
        .mc_op_e       (mc_op_e),
        .rd_m          (rd_m),
        .rd_w          (rd_w),
        .reg_write_m   (reg_write_m),
        .reg_write_w   (reg_write_w),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .forward_ae    (forward_ae),
        .forward_be    (forward_be),
        .mc_busy       (mc_busy),
        .mc_done       (mc_done),
        .mc_rd         (mc_rd),
        .stall_cnt     (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {mc_op_d, result_src_e0, pc_src_e, mc_op_e, reg_write_m, reg_write_w} = '0;
        #2;
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        check("rst_busy", 32'(mc_busy), 0);
        check("rst_done", 32'(mc_done), 0);
        check("rst_mc_rd", 32'(mc_rd), 0);
        check("rst_stall", 32'(stall_f), 0);
        // forwarding is combinational even in reset
        rs1_e = 5; rd_m = 5; reg_write_m = 1'b1; #1;
        check("rst_fwd_ae", 32'(forward_ae), 2);
        tick();
        tick();
        rst_n = 1'b1;

        // forwarding: M priority over W, x0 never forwards
        rd_w = 5; reg_write_w = 1'b1; #1;
        check("fwd_ae_m", 32'(forward_ae), 2);
        rs1_e = 0; #1;
        check("fwd_ae_x0", 32'(forward_ae), 0);
        rs2_e = 5; reg_write_m = 1'b0; #1;
        check("fwd_be_w", 32'(forward_be), 1);
        rs2_e = 6; #1;
        check("fwd_be_rf", 32'(forward_be), 0);
        pc_src_e = 1'b1; #1;
        check("br_flush_d", 32'(flush_d), 1);
        check("br_flush_e", 32'(flush_e), 1);
        check("br_stall", 32'(stall_f), 0);
        pc_src_e = 1'b0;
        reg_write_w = 1'b0;

        // load-use
        result_src_e0 = 1'b1; rd_e = 7; rs2_d = 7; #1;
        check("lw_stall_f", 32'(stall_f), 1);
        check("lw_stall_d", 32'(stall_d), 1);
        check("lw_flush_e", 32'(flush_e), 1);
        check("lw_flush_d", 32'(flush_d), 0);
        tick();
        check("lw_cnt", 32'(stall_cnt), 1);
        rd_e = 0; #1;
        check("lw_rd0", 32'(stall_f), 0);
        tick();
        check("lw_cnt_hold", 32'(stall_cnt), 1);
        result_src_e0 = 1'b0; rs2_d = 0;

        // multi-cycle op to x9, consumer in D throughout
        mc_op_e = 1'b1; rd_e = 9; #1;
        check("mc_pre_busy", 32'(mc_busy), 0);
        tick();
        mc_op_e = 1'b0; rd_e = 0; rs1_d = 9; #1;
        check("mc_busy_c1", 32'(mc_busy), 1);
        check("mc_done_c1", 32'(mc_done), 0);
        check("mc_sb_stall_c1", 32'(stall_f), 1);
        tick();
        check("mc_done_c2", 32'(mc_done), 0);
        tick();
        check("mc_done_c3", 32'(mc_done), 0);
        tick();
        check("mc_done_c4", 32'(mc_done), 1);
        check("mc_rd_c4", 32'(mc_rd), 9);
        check("mc_stall_done", 32'(stall_f), 1);
        tick();
        check("mc_done_c5", 32'(mc_done), 0);
        check("mc_busy_c5", 32'(mc_busy), 0);
        check("mc_stall_rel", 32'(stall_f), 0);
        check("mc_cnt", 32'(stall_cnt), 5);
        rs1_d = 0;

        // structural, WAW, and an ignored issue while BUSY
        mc_op_e = 1'b1; rd_e = 9;
        tick();
        mc_op_e = 1'b0; rd_e = 0; mc_op_d = 1'b1; #1;
        check("struct_stall", 32'(stall_f), 1);
        mc_op_d = 1'b0; rd_d = 9; #1;
        check("waw_stall", 32'(stall_f), 1);
        rd_d = 0; mc_op_e = 1'b1; rd_e = 3; #1;
        check("busy_no_stall", 32'(stall_f), 0);
        tick();
        mc_op_e = 1'b0; rd_e = 0; rs1_d = 3; #1;
        check("busy_issue_ignored", 32'(stall_f), 0);
        rs1_d = 0;
        tick();
        tick();
        check("b2b_done", 32'(mc_done), 1);
        check("b2b_mc_rd", 32'(mc_rd), 9);

        // back-to-back re-issue of x9 in the DONE cycle
        mc_op_e = 1'b1; rd_e = 9;
        tick();
        mc_op_e = 1'b0; rd_e = 0; rs1_d = 9; #1;
        check("b2b_busy", 32'(mc_busy), 1);
        check("b2b_done_low", 32'(mc_done), 0);
        check("b2b_sb9", 32'(stall_f), 1);

        // reset while BUSY
        tick();
        rst_n = 1'b0; #1;
        check("rst_mid_busy", 32'(mc_busy), 0);
        check("rst_mid_sb", 32'(stall_f), 0);
        check("rst_mid_cnt", 32'(stall_cnt), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_no_done", 32'(mc_done), 0);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst_done", 32'(mc_done), 0);
        check("post_rst_sb", 32'(stall_f), 0);
        rs1_d = 0;

        // stall counter saturation
        result_src_e0 = 1'b1; rd_e = 7; rs1_d = 7;
        for (int i = 0; i < 15; i++) tick();
        check("sat_full", 32'(stall_cnt), 15);
        for (int i = 0; i < 3; i++) tick();
        check("sat_hold", 32'(stall_cnt), 15);
        result_src_e0 = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
